// File: rtl/map_drawer.sv
// rtl/map_drawer.sv - full-screen tile map renderer streaming one plot per pixel.
// Optional MAP_DRAWER_SKIP_PATH_EN: path tiles are fetched but never drawn.
module map_drawer #(
  parameter int          TILE        = 4,
  parameter int          X_OFFSET    = 26,
  parameter int          Y_OFFSET    = 12,
  parameter logic [2:0]  WALL_COLOUR = 3'b001,
  parameter logic [2:0]  PATH_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       map_q,
  output logic [7:0] map_x,
  output logic [6:0] map_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int          PW      = (TILE > 1) ? $clog2(TILE) : 1;
  localparam logic [PW-1:0] PX_LAST = PW'(TILE - 1);

`ifdef MAP_DRAWER_SKIP_PATH_EN
  localparam bit SKIP_PATH = 1'b1;
`else
  localparam bit SKIP_PATH = 1'b0;
`endif

  logic [1:0]    r_state;
  logic [4:0]    r_tx, r_ty;
  logic [PW-1:0] r_px, r_py;
  logic          r_wall;
  logic [7:0]    r_map_x, r_vga_x;
  logic [6:0]    r_map_y, r_vga_y;
  logic [2:0]    r_colour;
  logic          r_plot, r_busy, r_done;

  logic          w_last_px, w_last_tile, w_enter_draw, w_adv;
  logic [4:0]    w_tx_n, w_ty_n;
  logic [PW-1:0] w_px_n, w_py_n;

  function automatic logic [7:0] f_x(input logic [4:0] tx, input logic [PW-1:0] px);
    return 8'(X_OFFSET + 32'(tx) * TILE + 32'(px));
  endfunction

  function automatic logic [6:0] f_y(input logic [4:0] ty, input logic [PW-1:0] py);
    return 7'(Y_OFFSET + 32'(ty) * TILE + 32'(py));
  endfunction

  assign w_last_px   = (r_px == PX_LAST) && (r_py == PX_LAST);
  assign w_last_tile = (r_tx == 5'd26) && (r_ty == 5'd23);
  assign w_tx_n      = (r_tx == 5'd26) ? 5'd0 : r_tx + 5'd1;
  assign w_ty_n      = (r_tx == 5'd26) ? r_ty + 5'd1 : r_ty;
  assign w_px_n      = (r_px == PX_LAST) ? '0 : r_px + PW'(1);
  assign w_py_n      = (r_px == PX_LAST) ? r_py + PW'(1) : r_py;

  // A tile finishes after its last pixel, or straight from FETCH when path tiles are skipped.
  assign w_enter_draw = (r_state == S_FETCH) && (map_q || !SKIP_PATH);
  assign w_adv        = ((r_state == S_DRAW) && w_last_px) ||
                        ((r_state == S_FETCH) && !map_q && SKIP_PATH);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_tx     <= '0;
      r_ty     <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_wall   <= 1'b0;
      r_map_x  <= '0;
      r_map_y  <= '0;
      r_vga_x  <= '0;
      r_vga_y  <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_tx    <= '0;
            r_ty    <= '0;
            r_map_x <= '0;
            r_map_y <= '0;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_wall <= map_q;
          if (w_enter_draw) begin
            r_px     <= '0;
            r_py     <= '0;
            r_vga_x  <= f_x(r_tx, '0);
            r_vga_y  <= f_y(r_ty, '0);
            r_colour <= map_q ? WALL_COLOUR : PATH_COLOUR;
            r_plot   <= 1'b1;
            r_state  <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (w_last_px) begin
            r_plot <= 1'b0;
          end else begin
            r_px     <= w_px_n;
            r_py     <= w_py_n;
            r_vga_x  <= f_x(r_tx, w_px_n);
            r_vga_y  <= f_y(r_ty, w_py_n);
            r_colour <= r_wall ? WALL_COLOUR : PATH_COLOUR;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase

      if (w_adv) begin
        if (w_last_tile) begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end else begin
          r_tx    <= w_tx_n;
          r_ty    <= w_ty_n;
          r_map_x <= 8'(w_tx_n);
          r_map_y <= 7'(w_ty_n);
          r_state <= S_FETCH;
        end
      end
    end
  end

  assign map_x  = r_map_x;
  assign map_y  = r_map_y;
  assign vga_x  = r_vga_x;
  assign vga_y  = r_vga_y;
  assign colour = r_colour;
  assign plot   = r_plot;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_map_drawer.sv
// tb/tb_map_drawer.sv - randomized self-checking bench for map_drawer against a pixel-list model.
module tb_map_drawer;

  localparam int         TILE = 4;
  localparam int         XO   = 26;
  localparam int         YO   = 12;
  localparam logic [2:0] WALL = 3'b001;
  localparam logic [2:0] PATH = 3'b000;
`ifdef MAP_DRAWER_SKIP_PATH_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, start, map_q;
  logic [7:0] map_x, vga_x;
  logic [6:0] map_y, vga_y;
  logic [2:0] colour;
  logic       plot, busy, done;

  map_drawer dut (
    .clock(clock), .reset(reset), .start(start), .map_q(map_q),
    .map_x(map_x), .map_y(map_y), .vga_x(vga_x), .vga_y(vga_y),
    .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  bit tb_map [0:26][0:23];
  assign map_q = (map_x < 8'd27 && map_y < 7'd24) ? tb_map[map_x][map_y] : 1'b0;

  typedef logic [17:0] pix_t;
  pix_t exp_q[$];
  int   exp_drawn;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic pix_t mk(input int x, input int y, input logic [2:0] c);
    return {8'(x), 7'(y), c};
  endfunction

  // Random map plus the complete ordered list of pixels the frame must produce.
  task automatic new_map();
    for (int x = 0; x < 27; x++)
      for (int y = 0; y < 24; y++)
        tb_map[x][y] = 1'($urandom_range(0, 1));
    tb_map[0][0]   = 1'b1;
    tb_map[0][10]  = 1'b0;
    tb_map[26][23] = 1'b1;
    exp_q.delete();
    exp_drawn = 0;
    for (int ty = 0; ty < 24; ty++)
      for (int tx = 0; tx < 27; tx++)
        if (tb_map[tx][ty] || !SKIP) begin
          exp_drawn++;
          for (int py = 0; py < TILE; py++)
            for (int px = 0; px < TILE; px++)
              exp_q.push_back(mk(XO + tx * TILE + px, YO + ty * TILE + py,
                                 tb_map[tx][ty] ? WALL : PATH));
        end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_map_xy"}, {map_x, map_y}, 0);
    check({tag, "_vga_xy"}, {vga_x, vga_y}, 0);
    check({tag, "_colour"}, colour, 0);
    check({tag, "_ctl"}, {plot, busy, done}, 0);
  endtask

  task automatic run_frame(input int abort_at);
    int   n, plots, busy_cyc, path_px, done_at;
    pix_t got, exp, last;
    plots = 0; busy_cyc = 0; path_px = 0; done_at = 0; last = '0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    check("k1_busy", busy, 1);
    check("k1_map_xy", {map_x, map_y}, 0);
    check("k1_plot", plot, 0);
    n = 1;
    while (done_at == 0 && n < 12000) begin
      if (busy) busy_cyc++;
      if (plot) begin
        plots++;
        got  = {vga_x, vga_y, colour};
        last = got;
        exp  = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        check("pix", got, exp);
        if (vga_x >= 26 && vga_x <= 29 && vga_y >= 52 && vga_y <= 55 && colour == PATH)
          path_px++;
        if (n == 2) check("first_px", got, mk(26, 12, WALL));
      end
      if (done) done_at = n;
      if (n == 100) start = 1'b1;
      if (n == 101) start = 1'b0;
      if (abort_at != 0 && n == abort_at) return;
      n++;
      @(negedge clock);
    end
    check("done_cycle", done_at, 1 + 648 + TILE * TILE * exp_drawn);
    check("plot_count", plots, TILE * TILE * exp_drawn);
    check("busy_cycles", busy_cyc, 648 + TILE * TILE * exp_drawn);
    check("pix_left", exp_q.size(), 0);
    check("last_px", last, mk(133, 107, WALL));
    check("path_tile_px", path_px, SKIP ? 0 : 16);
    @(negedge clock);
    check("done_pulse", {done, busy}, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    check_zero("rst");
    reset = 1'b0;
    @(negedge clock);
    check_zero("idle");

    reset = 1'b1; start = 1'b1;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    check("rst_start_busy", {busy, plot}, 0);

    new_map();
    run_frame(0);

    new_map();
    run_frame(3000);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_zero("midrst");
    repeat (5) @(negedge clock);
    check("midrst_idle", {busy, plot, done}, 0);

    new_map();
    run_frame(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/map_drawer.md
# map_drawer

Full-screen renderer for the maze tile map. On a `start` pulse it walks every tile (x 0–26, y 0–23), queries the combinational map lookup through `map_x`/`map_y`/`map_q`, and streams one plot command per pixel to the VGA adapter. Each tile is drawn as a TILE×TILE block, in wall or path colour. It sits between the map lookup and the VGA adapter's plot port, and is used at game reset and level restart.

## Interface
- `TILE`, 4: tile edge in pixels (power of two, 1–4).
- `X_OFFSET`, 26: screen x of tile (0,0)'s top-left pixel.
- `Y_OFFSET`, 12: screen y of tile (0,0)'s top-left pixel.
- `WALL_COLOUR`, 3'b001: colour for tiles with `map_q`=1.
- `PATH_COLOUR`, 3'b000: colour for tiles with `map_q`=0.

- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle request to draw the whole map.
- `map_q` in 1: wall bit returned for (`map_x`, `map_y`), valid in the same cycle.
- `map_x` out 8: tile column being queried.
- `map_y` out 7: tile row being queried.
- `vga_x` out 8: pixel x.
- `vga_y` out 7: pixel y.
- `colour` out 3: pixel colour.
- `plot` out 1: write-enable to the VGA adapter; a pixel is written in every cycle `plot`=1.
- `busy` out 1: high from the cycle after `start` is accepted until the last pixel.
- `done` out 1: one-cycle pulse after the last tile.

## Operation
- States: IDLE, FETCH, DRAW, DONE.
- IDLE: `start`=1 clears tile counters tx=0, ty=0 and goes to FETCH.
- FETCH (1 cycle): drives `map_x`=tx, `map_y`=ty, and latches `map_q` into `wall`. Clears pixel counters px=0, py=0 and goes to DRAW.
- DRAW (TILE² cycles):
  - `plot`=1.
  - `vga_x`=X_OFFSET+tx·TILE+px, `vga_y`=Y_OFFSET+ty·TILE+py, both truncated to the port width.
  - `colour`=`wall` ? WALL_COLOUR : PATH_COLOUR.
  - px increments fastest; py increments when px wraps from TILE−1.
  - After pixel (TILE−1, TILE−1), the tile advances: tx increments; at tx=26 it wraps to 0 and ty increments.
  - If the finished tile was (26,23), go to DONE; otherwise go to FETCH.
- DONE (1 cycle): `done`=1, `busy`=0, then IDLE.
- Scan order: row-major (ty outer, tx inner), 648 tiles.
- `start` while not in IDLE is ignored; no queueing.
- `map_x`/`map_y` hold their last value outside FETCH.
- `vga_x`/`vga_y`/`colour` hold their last value when `plot`=0.
- Reset: all outputs 0 the cycle after `reset` is sampled high, counters cleared, state IDLE. This applies mid-draw as well; the partial frame is not resumed.
- `reset` and `start` asserted together: reset wins.

## Timing
- `start` sampled at edge k:
  - FETCH in cycle k+1 with `busy`=1 and `map_x`=0, `map_y`=0.
  - First `plot`=1 in cycle k+2.
- Per tile: 1 + TILE² cycles (17 at default).
- Full frame: 648·(1+TILE²) busy cycles (11016 at default). `done` lands in cycle k+11017.
- All outputs are registered; the `map_q` path is combinational into the `wall` register only.

## Configuration
- `MAP_DRAWER_SKIP_PATH_EN` defined:
  - A FETCH that reads `map_q`=0 skips DRAW entirely and advances to the next tile.
  - A path tile costs 1 cycle, and PATH_COLOUR is never emitted.
  - Frame length = 648 + 16·(wall tiles) at default TILE.
- Not defined: every tile is drawn; frame length is fixed as above.

## Test plan
- Reset then `start` at edge k:
  - `busy`=1 at k+1 with `map_x`=0, `map_y`=0.
  - Cycle k+2: `plot`=1, `vga_x`=26, `vga_y`=12, `colour`=3'b001 (tile (0,0) is a wall).
- Full frame, macro off:
  - Exactly 10368 plot cycles.
  - `done` pulses once at k+11017.
  - Last pixel is `vga_x`=26+26·4+3=133, `vga_y`=12+23·4+3=107.
  - Scoreboard against a map model: every pixel's colour matches `map_q` of its tile.
- Path tile (0,10), macro off: 16 pixels at x 26–29, y 52–55 with `colour`=3'b000.
- Macro on: no plot with `colour`=PATH_COLOUR; plot count = 16 × (FETCH cycles with `map_q`=1); `done` at k+1+648+16·walls.
- `start` re-pulsed while busy, and `reset` pulsed mid-frame:
  - The re-pulsed `start` has no effect.
  - After reset, all outputs are 0 and the state is IDLE.
  - A subsequent `start` redraws from tile (0,0).
